i2s_mixer_tx: RTL and testbench
===============================

I2S_MIXER_TX -- requirements
Module: i2s_mixer_tx

Interface
REQ-001 SHALL have parameter NCH, default 2: number of stereo sources mixed (1..8).
REQ-002 SHALL have parameter DW, default 16: I2S slot width per channel (16, 24 or 32).
REQ-003 SHALL have parameter HALF_DIV, default 8: clk cycles per bclk half-period (≥2); at 50 MHz, 8 gives bclk = 3.125 MHz.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port audio_l, input, NCH*16: signed left samples; source n occupies bits [16n+15:16n].
REQ-007 SHALL have port audio_r, input, NCH*16: signed right samples, same packing as audio_l.
REQ-008 SHALL have port att, input, NCH*4: per-source arithmetic right-shift attenuation, 0..15.
REQ-009 SHALL have port mute, input, NCH: per-source mute, active high.
REQ-010 SHALL have port i2s_bclk, output, 1: bit clock.
REQ-011 SHALL have port i2s_lrclk, output, 1: word select; 0 = left, 1 = right.
REQ-012 SHALL have port i2s_dout, output, 1: serial data, MSB first.
REQ-013 SHALL have port sample_strobe, output, 1: one-clk pulse when a new stereo frame is loaded.
REQ-014 SHALL have port clip_l, output, 1: high for one frame when the loaded left word saturated.
REQ-015 SHALL have port clip_r, output, 1: high for one frame when the loaded right word saturated.

Function
REQ-016 SHALL run a divider counter 0..HALF_DIV-1 and toggle bclk on each wrap.
REQ-017 SHALL run a slot counter 0..2*DW-1 that advances on every bclk falling edge and wraps to 0.
REQ-018 SHALL drive lrclk to 1 for slot counts DW-1..2*DW-2 and to 0 otherwise, giving the standard one-bclk I2S delay.
REQ-019 SHALL change dout only on bclk falling edges; slots 0..DW-1 carry left MSB..LSB and slots DW..2*DW-1 carry right MSB..LSB.
REQ-020 SHALL compute each source term as 0 when muted, else the sample arithmetically shifted right by att.
REQ-021 SHALL sum all NCH terms per side at width 16+clog2(NCH)+1 with no overflow, then reduce to 16 bits per REQ-030/REQ-031.
REQ-022 SHALL register the mix result every clk (1-clk pipeline); the shift registers load the registered mix.
REQ-023 SHALL left-align the 16-bit mix into DW bits with zero LSB padding.
REQ-024 SHALL load both shift registers, pulse sample_strobe and update clip_l/clip_r on the clk cycle the slot counter wraps 2*DW-1 -> 0.
REQ-025 SHALL hold mixed-input changes made mid-frame until the next load; a frame never mixes two input snapshots.
REQ-026 SHALL produce frame rate = clk / (4*HALF_DIV*DW).

Reset
REQ-027 SHALL clear both counters and set bclk=0, lrclk=0, dout=0, sample_strobe=0, clip_l=0, clip_r=0, shift registers=0 and mix registers=0 on reset.
REQ-028 SHALL make the first frame after reset all zeros; the first sample_strobe occurs at the end of that frame.
REQ-029 SHALL abandon a mid-frame reset immediately, without completing the partial word.

Configuration
REQ-030 SHALL, with I2S_MIX_SATURATE_EN defined, clamp the sum to +32767/-32768 and flag clip on a clamped side.
REQ-031 SHALL, without I2S_MIX_SATURATE_EN, truncate the sum to its low 16 bits (two's-complement wrap) and hold clip_l and clip_r at 0.

Structure
REQ-032 SHALL place the constants SRC_W=16 and ATT_W=4 and the clog2 function in shared package audio_pkg.
REQ-033 SHALL implement the per-side attenuate/mute/sum/saturate path as one sub-module, i2s_mix_sum, instantiated twice (left and right).

Verification
REQ-034 SHALL cover: NCH=1, DW=16, HALF_DIV=8, audio_l=16'h8001, audio_r=16'h7FFE, att=0 -> bclk period 16 clk, frame 512 clk, serial left word 8001, right word 7FFE, lrclk one bclk ahead of the MSB.
REQ-035 SHALL cover: NCH=2, sources 16'h4000 and 16'h4000, macro defined -> left word 7FFF, clip_l=1; macro undefined -> left word 8000, clip_l=0.
REQ-036 SHALL cover: NCH=2, source0=16'h1000 with att=4, source1=16'hF000 muted -> left word 0100.
REQ-037 SHALL cover: DW=24, input 16'h1234 -> serial word 24'h123400, frame 768 clk.
REQ-038 SHALL cover: reset asserted at slot 10 -> all outputs 0 on the next clk; after release one zero frame, then sample_strobe and correct data.
REQ-039 SHALL cover: input changed mid-frame -> new value first appears in the following frame, never split across slots.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the I2S mixer transmitter.
package audio_pkg;

  localparam int SRC_W = 16;
  localparam int ATT_W = 4;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_mix_sum.sv
// One side of the mixer: per-source mute/attenuate, wide sum, reduce to 16 bits.
// I2S_MIX_SATURATE_EN selects clamping with clip flag; otherwise the sum wraps.
module i2s_mix_sum
  import audio_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH*SRC_W-1:0] samples_i,
  input  logic [NCH*ATT_W-1:0] att_i,
  input  logic [NCH-1:0]       mute_i,
  output logic [SRC_W-1:0]     mix_o,
  output logic                 clip_o
);

  localparam int SUM_W = SRC_W + clog2(NCH) + 1;

  logic signed [SUM_W-1:0] term [NCH];
  logic signed [SUM_W-1:0] sum;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_src
    logic signed [SRC_W-1:0] smp;
    logic signed [SRC_W-1:0] shifted;
    assign smp      = samples_i[gi*SRC_W +: SRC_W];
    assign shifted  = smp >>> att_i[gi*ATT_W +: ATT_W];
    assign term[gi] = mute_i[gi] ? '0 : {{(SUM_W-SRC_W){shifted[SRC_W-1]}}, shifted};
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = sum + term[i];
    end
  end

`ifdef I2S_MIX_SATURATE_EN
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(-32768);

  always_comb begin
    mix_o  = sum[SRC_W-1:0];
    clip_o = 1'b0;
    if (sum > MAX_V) begin
      mix_o  = 16'h7FFF;
      clip_o = 1'b1;
    end else if (sum < MIN_V) begin
      mix_o  = 16'h8000;
      clip_o = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum[SUM_W-1:SRC_W];
  assign mix_o     = sum[SRC_W-1:0];
  assign clip_o    = 1'b0;
`endif

endmodule

// File: rtl/i2s_mixer_tx.sv
// Multi-source stereo mixer feeding an I2S master transmitter (bclk/lrclk/dout).
// Build option I2S_MIX_SATURATE_EN enables clamping and the clip_l/clip_r flags.
module i2s_mixer_tx
  import audio_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DW       = 16,
  parameter int HALF_DIV = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*SRC_W-1:0] audio_l,
  input  logic [NCH*SRC_W-1:0] audio_r,
  input  logic [NCH*ATT_W-1:0] att,
  input  logic [NCH-1:0]       mute,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_dout,
  output logic                 sample_strobe,
  output logic                 clip_l,
  output logic                 clip_r
);

  localparam int DIV_W  = clog2(HALF_DIV);
  localparam int SLOT_W = clog2(2*DW);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              bclk_q, lrclk_q, lrclk_d, strobe_q;
  logic              clip_l_q, clip_r_q, mclip_l_q, mclip_r_q;
  logic [SRC_W-1:0]  mix_l_q, mix_r_q;
  logic [DW-1:0]     sr_l_q, sr_r_q;
  logic [SRC_W-1:0]  mix_l, mix_r;
  logic              sum_clip_l, sum_clip_r;
  logic              div_wrap, bclk_fall, slot_last;

  i2s_mix_sum #(.NCH(NCH)) u_sum_l (
    .samples_i(audio_l), .att_i(att), .mute_i(mute), .mix_o(mix_l), .clip_o(sum_clip_l)
  );
  i2s_mix_sum #(.NCH(NCH)) u_sum_r (
    .samples_i(audio_r), .att_i(att), .mute_i(mute), .mix_o(mix_r), .clip_o(sum_clip_r)
  );

  assign div_wrap  = (div_q == DIV_W'(HALF_DIV-1));
  assign bclk_fall = div_wrap & bclk_q;
  assign slot_last = (slot_q == SLOT_W'(2*DW-1));

  always_comb begin
    div_d  = div_wrap ? '0 : div_q + DIV_W'(1);
    slot_d = slot_q;
    if (bclk_fall) slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
    // lrclk leads the word by one bclk, as standard I2S requires
    lrclk_d = (slot_d >= SLOT_W'(DW-1)) && (slot_d <= SLOT_W'(2*DW-2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      slot_q    <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      strobe_q  <= 1'b0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      mclip_l_q <= 1'b0;
      mclip_r_q <= 1'b0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      sr_l_q    <= '0;
      sr_r_q    <= '0;
    end else begin
      div_q     <= div_d;
      slot_q    <= slot_d;
      lrclk_q   <= lrclk_d;
      mix_l_q   <= mix_l;
      mix_r_q   <= mix_r;
      mclip_l_q <= sum_clip_l;
      mclip_r_q <= sum_clip_r;
      strobe_q  <= bclk_fall & slot_last;
      if (div_wrap) bclk_q <= ~bclk_q;
      if (bclk_fall) begin
        if (slot_last) begin
          sr_l_q   <= DW'(mix_l_q) << (DW - SRC_W);
          sr_r_q   <= DW'(mix_r_q) << (DW - SRC_W);
          clip_l_q <= mclip_l_q;
          clip_r_q <= mclip_r_q;
        end else begin
          {sr_l_q, sr_r_q} <= {sr_l_q[DW-2:0], sr_r_q, 1'b0};
        end
      end
    end
  end

  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lrclk_q;
  assign i2s_dout      = sr_l_q[DW-1];
  assign sample_strobe = strobe_q;
  assign clip_l        = clip_l_q;
  assign clip_r        = clip_r_q;

endmodule

// File: tb/tb_i2s_mixer_tx.sv
// Directed bench for i2s_mixer_tx: three instances (NCH=1/DW=16, NCH=2/DW=16, DW=24).
// Expected words follow I2S_MIX_SATURATE_EN when the bench is built with it.
module tb_i2s_mixer_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] l0, r0, l2, r2;
  logic [31:0] l1, r1;
  logic [3:0]  att0, att2;
  logic [7:0]  att1;
  logic        m0, m2;
  logic [1:0]  m1;

  wire [2:0] bclk_w, lrclk_w, dout_w, strobe_w, clipl_w, clipr_w;

  i2s_mixer_tx #(.NCH(1), .DW(16), .HALF_DIV(8)) u0 (
    .clk(clk), .reset(reset), .audio_l(l0), .audio_r(r0), .att(att0), .mute(m0),
    .i2s_bclk(bclk_w[0]), .i2s_lrclk(lrclk_w[0]), .i2s_dout(dout_w[0]),
    .sample_strobe(strobe_w[0]), .clip_l(clipl_w[0]), .clip_r(clipr_w[0]));

  i2s_mixer_tx #(.NCH(2), .DW(16), .HALF_DIV(2)) u1 (
    .clk(clk), .reset(reset), .audio_l(l1), .audio_r(r1), .att(att1), .mute(m1),
    .i2s_bclk(bclk_w[1]), .i2s_lrclk(lrclk_w[1]), .i2s_dout(dout_w[1]),
    .sample_strobe(strobe_w[1]), .clip_l(clipl_w[1]), .clip_r(clipr_w[1]));

  i2s_mixer_tx #(.NCH(1), .DW(24), .HALF_DIV(8)) u2 (
    .clk(clk), .reset(reset), .audio_l(l2), .audio_r(r2), .att(att2), .mute(m2),
    .i2s_bclk(bclk_w[2]), .i2s_lrclk(lrclk_w[2]), .i2s_dout(dout_w[2]),
    .sample_strobe(strobe_w[2]), .clip_l(clipl_w[2]), .clip_r(clipr_w[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lr_model(input int dw);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < 2*dw; s++) v[s] = (s >= dw-1) && (s <= 2*dw-2);
    return v;
  endfunction

  // Waits for a strobe; dor collects dout over the cycles before it.
  task automatic wait_strobe(input int d, input int budget, output int cnt, output logic dor);
    cnt = 0;
    dor = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (!strobe_w[d]) dor = dor | dout_w[d];
    end while (!strobe_w[d] && cnt < budget);
  endtask

  // Called on the negedge that shows the strobe; samples each slot mid-bit and
  // returns on the negedge that shows the following strobe.
  task automatic grab(input int d, input int dw, input int h, input int chg_slot,
                      output logic [31:0] wl, output logic [31:0] wr, output logic [63:0] lr);
    wl = '0;
    wr = '0;
    lr = '0;
    for (int s = 0; s < 2*dw; s++) begin
      repeat (h) @(negedge clk);
      if (s < dw) wl = {wl[30:0], dout_w[d]};
      else        wr = {wr[30:0], dout_w[d]};
      lr[s] = lrclk_w[d];
      if (s == chg_slot) begin
        l1   = {16'hF000, 16'h1000};
        r1   = {16'hF000, 16'h1000};
        att1 = {4'h0, 4'h4};
        m1   = 2'b10;
      end
      repeat (h) @(negedge clk);
    end
  endtask

  int          cnt, cnt2;
  logic        dor, pb;
  logic [31:0] wl, wr;
  logic [63:0] lr;
  int          t_rise [2];
  int          nr;
  logic [15:0] exp_sat;
  logic        exp_clip;

  initial begin
`ifdef I2S_MIX_SATURATE_EN
    exp_sat  = 16'h7FFF;
    exp_clip = 1'b1;
`else
    exp_sat  = 16'h8000;
    exp_clip = 1'b0;
`endif
    reset = 1'b1;
    l0 = 16'h8001; r0 = 16'h7FFE; att0 = 4'h0; m0 = 1'b0;
    l1 = {16'h4000, 16'h4000}; r1 = {16'hFFFF, 16'h0100}; att1 = 8'h00; m1 = 2'b00;
    l2 = 16'h1234; r2 = 16'hABCD; att2 = 4'h0; m2 = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs_u0", {bclk_w[0], lrclk_w[0], dout_w[0], strobe_w[0], clipl_w[0], clipr_w[0]}, 64'h0);
    check("reset_outputs_u2", {bclk_w[2], lrclk_w[2], dout_w[2], strobe_w[2]}, 64'h0);

    // First frame after reset: all zeros, strobe at its end
    reset = 1'b0;
    wait_strobe(0, 2000, cnt, dor);
    check("first_strobe_latency_u0", 64'(cnt), 64'd512);
    check("first_frame_zero_u0", 64'(dor), 64'd0);
    wait_strobe(2, 2000, cnt2, dor);
    check("first_strobe_latency_u2", 64'(cnt + cnt2), 64'd768);

    // DW=24 word padding and frame length
    grab(2, 24, 8, -1, wl, wr, lr);
    check("u2_left_word", 64'(wl), 64'h123400);
    check("u2_right_word", 64'(wr), 64'hABCD00);
    check("u2_lrclk_pattern", lr, lr_model(24));
    check("u2_strobe_after_frame", 64'(strobe_w[2]), 64'd1);
    wait_strobe(2, 2000, cnt, dor);
    check("u2_frame_period", 64'(cnt), 64'd768);

    // NCH=1, DW=16 basic serialisation
    wait_strobe(0, 2000, cnt, dor);
    check("u0_strobe_seen", 64'(strobe_w[0]), 64'd1);
    check("u0_clip_flags", {clipl_w[0], clipr_w[0]}, 64'd0);
    grab(0, 16, 8, -1, wl, wr, lr);
    check("u0_left_word", 64'(wl), 64'h8001);
    check("u0_right_word", 64'(wr), 64'h7FFE);
    check("u0_lrclk_pattern", lr, lr_model(16));
    @(negedge clk);
    check("u0_strobe_one_clk", 64'(strobe_w[0]), 64'd0);
    wait_strobe(0, 2000, cnt, dor);
    check("u0_frame_period", 64'(cnt + 1), 64'd512);

    t_rise[0] = 0;
    t_rise[1] = 0;
    nr = 0;
    pb = bclk_w[0];
    for (int i = 1; i <= 100 && nr < 2; i++) begin
      @(negedge clk);
      if (bclk_w[0] && !pb) begin
        t_rise[nr] = i;
        nr++;
      end
      pb = bclk_w[0];
    end
    check("u0_bclk_period", 64'(t_rise[1] - t_rise[0]), 64'd16);

    // NCH=2: overflow handling, then a mid-frame change at slot 10
    wait_strobe(1, 1000, cnt, dor);
    check("u1_clip_l_overflow", 64'(clipl_w[1]), 64'(exp_clip));
    check("u1_clip_r_overflow", 64'(clipr_w[1]), 64'd0);
    grab(1, 16, 2, 10, wl, wr, lr);
    check("u1_left_overflow_word", 64'(wl), 64'(exp_sat));
    check("u1_right_word_pre_change", 64'(wr), 64'h00FF);
    check("u1_strobe_after_frame", 64'(strobe_w[1]), 64'd1);
    check("u1_clip_l_after_change", 64'(clipl_w[1]), 64'd0);
    grab(1, 16, 2, -1, wl, wr, lr);
    check("u1_left_att_mute_word", 64'(wl), 64'h0100);
    check("u1_right_word_post_change", 64'(wr), 64'h0100);
    check("u1_lrclk_pattern", lr, lr_model(16));

    // Reset in the middle of a u0 frame, around slot 10
    wait_strobe(0, 2000, cnt, dor);
    repeat (10*16 + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs_u0", {bclk_w[0], lrclk_w[0], dout_w[0], strobe_w[0], clipl_w[0], clipr_w[0]}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_strobe(0, 2000, cnt, dor);
    check("post_reset_strobe_latency", 64'(cnt), 64'd512);
    check("post_reset_zero_frame", 64'(dor), 64'd0);
    grab(0, 16, 8, -1, wl, wr, lr);
    check("post_reset_left_word", 64'(wl), 64'h8001);
    check("post_reset_right_word", 64'(wr), 64'h7FFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
